mem_dcache_port_arbiter: RTL

MEM_DCACHE_PORT_ARBITER -- requirements
Module: mem_dcache_port_arbiter

---
 rtl/mem_dcache_port_arbiter_pkg.sv | 57 +++++
 rtl/mem_dcache_id_fifo.sv | 65 ++++++
 rtl/mem_dcache_port_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_dcache_port_arbiter_pkg.sv
// Shared definitions for the MEM-to-DCACHE port arbiter.
// Holds the uninasoc MEM bus widths, the requester id and id-FIFO entry
// types, a minimal CVA6 cache-geometry configuration record, the DCACHE
// request/response payloads, and the arbiter FSM state encoding.
package mem_dcache_port_arbiter_pkg;

   // uninasoc MEM bus
   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned MEM_DATA_W = 32;
   localparam int unsigned MEM_BE_W   = MEM_DATA_W / 8;

   // Requester ids are sized for the largest supported port count (4)
   localparam int unsigned MAX_PORTS = 4;
   localparam int unsigned PORT_ID_W = $clog2(MAX_PORTS);

   typedef logic [PORT_ID_W-1:0] port_id_t;

   typedef struct packed {
      port_id_t id;
   } id_entry_t;

   // Cache geometry supplied by the CVA6 configuration
   typedef struct packed {
      int unsigned DCACHE_TAG_WIDTH;
      int unsigned DCACHE_INDEX_WIDTH;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{DCACHE_TAG_WIDTH: 20, DCACHE_INDEX_WIDTH: 12};

   localparam int unsigned DC_TAG_W   = 20;
   localparam int unsigned DC_INDEX_W = 12;

   // DCACHE request (arbiter -> cache)
   typedef struct packed {
      logic [DC_INDEX_W-1:0] address_index;
      logic [DC_TAG_W-1:0]   address_tag;
      logic [MEM_DATA_W-1:0] data_wdata;
      logic                  data_req;
      logic                  data_we;
      logic [MEM_BE_W-1:0]   data_be;
      logic                  tag_valid;
      logic                  kill_req;
   } dcache_req_t;

   // DCACHE response (cache -> arbiter)
   typedef struct packed {
      logic                  data_gnt;
      logic                  data_rvalid;
      logic [MEM_DATA_W-1:0] data_rdata;
   } dcache_rsp_t;

   typedef enum logic {
      IDLE     = 1'b0,
      SEND_TAG = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mem_dcache_id_fifo.sv
// Response-routing FIFO: records the requester id of every granted request
// so that in-order cache responses can be steered back to their owner.
// Ports: clk_i/rst_i (sync, active-high), push_i/data_i enqueue, pop_i
// dequeue, full_o/empty_o status, head_o oldest entry.
// A push and pop in the same cycle both take effect, also when full.
module mem_dcache_id_fifo
   import mem_dcache_port_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  id_entry_t data_i,
   input  logic      pop_i,
   output logic      full_o,
   output logic      empty_o,
   output id_entry_t head_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   id_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en, pop_en;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rptr_q];

   // Pop frees a slot in the same cycle, so a full FIFO may still accept a push
   assign pop_en  = pop_i && !empty_o;
   assign push_en = push_i && (!full_o || pop_en);

   // Pointers wrap naturally at the power-of-two depth
   always_comb begin : ptr_next
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_en) wptr_d = wptr_q + PTR_W'(1);
      if (pop_en)  rptr_d = rptr_q + PTR_W'(1);
      if (push_en && !pop_en)      count_d = count_q + CNT_W'(1);
      else if (pop_en && !push_en) count_d = count_q - CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin : ptr_reg
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin : mem_wr
      if (push_en) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/mem_dcache_port_arbiter.sv
// Round-robin arbiter from NUM_PORTS uninasoc MEM requesters onto one CVA6
// DCACHE request port. A request is issued in IDLE (index phase); on grant
// the tag is latched and presented for one cycle in SEND_TAG. Granted ids
// are queued so in-order responses are routed back to their requester.
// Ports: clk_i/rst_i (sync, active-high); s_mem_* per-requester MEM bus;
// req_port_i cache response; req_port_o cache request; err_o sticky flag
// for a response that arrives with no request outstanding.
module mem_dcache_port_arbiter
   import mem_dcache_port_arbiter_pkg::*;
#(
   parameter cva6_cfg_t   CVA6Cfg         = cva6_cfg_empty,
   parameter int unsigned NUM_PORTS       = 2,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter type         dcache_req_i_t  = dcache_req_t,
   parameter type         dcache_req_o_t  = dcache_rsp_t
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic [NUM_PORTS-1:0]                  s_mem_req,
   output logic [NUM_PORTS-1:0]                  s_mem_gnt,
   output logic [NUM_PORTS-1:0]                  s_mem_valid,
   input  logic [NUM_PORTS-1:0][MEM_ADDR_W-1:0]  s_mem_addr,
   input  logic [NUM_PORTS-1:0][MEM_DATA_W-1:0]  s_mem_wdata,
   input  logic [NUM_PORTS-1:0]                  s_mem_we,
   input  logic [NUM_PORTS-1:0][MEM_BE_W-1:0]    s_mem_be,
   output logic [NUM_PORTS-1:0][MEM_DATA_W-1:0]  s_mem_rdata,
   input  dcache_req_o_t                         req_port_i,
   output dcache_req_i_t                         req_port_o,
   output logic                                  err_o
);

   localparam int unsigned IDX_W = CVA6Cfg.DCACHE_INDEX_WIDTH;
   localparam int unsigned TAG_W = CVA6Cfg.DCACHE_TAG_WIDTH;

   arb_state_e       state_q, state_d;
   port_id_t         rr_ptr_q, rr_ptr_d;
   port_id_t         win_q, win_d;
   logic             lock_q, lock_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             err_q, err_d;

   // Requester signals widened to MAX_PORTS so they index cleanly by port_id_t
   logic [MAX_PORTS-1:0]                 req_ext, we_ext;
   logic [MAX_PORTS-1:0][MEM_ADDR_W-1:0] addr_ext;
   logic [MAX_PORTS-1:0][MEM_DATA_W-1:0] wdata_ext;
   logic [MAX_PORTS-1:0][MEM_BE_W-1:0]   be_ext;

   port_id_t  rr_win, win;
   logic      any_req, data_req, grant, tag_valid;
   logic      fifo_full, fifo_empty, fifo_pop;
   id_entry_t fifo_head;

   for (genvar p = 0; p < int'(MAX_PORTS); p++) begin : g_ext
      if (p < int'(NUM_PORTS)) begin : g_on
         assign req_ext[p]   = s_mem_req[p];
         assign we_ext[p]    = s_mem_we[p];
         assign addr_ext[p]  = s_mem_addr[p];
         assign wdata_ext[p] = s_mem_wdata[p];
         assign be_ext[p]    = s_mem_be[p];
      end else begin : g_off
         assign req_ext[p]   = 1'b0;
         assign we_ext[p]    = 1'b0;
         assign addr_ext[p]  = '0;
         assign wdata_ext[p] = '0;
         assign be_ext[p]    = '0;
      end
   end

   // First active requester at or after rr_ptr, wrapping at NUM_PORTS
   always_comb begin : rr_pick
      int unsigned cand;
      rr_win  = rr_ptr_q;
      any_req = 1'b0;
      cand    = 0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         cand = 32'(rr_ptr_q) + i;
         if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
         if (!any_req && req_ext[port_id_t'(cand)]) begin
            any_req = 1'b1;
            rr_win  = port_id_t'(cand);
         end
      end
   end

   // A request left waiting for data_gnt keeps its original winner
   assign win = lock_q ? win_q : rr_win;

   always_comb begin : fsm_comb
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      win_d     = win_q;
      lock_d    = 1'b0;
      tag_d     = tag_q;
      err_d     = err_q;
      data_req  = 1'b0;
      grant     = 1'b0;
      tag_valid = 1'b0;
      case (state_q)
         IDLE: begin
            data_req = (lock_q || any_req) && !fifo_full;
            grant    = data_req && req_port_i.data_gnt;
            if (grant) begin
               tag_d    = addr_ext[win][TAG_W+IDX_W-1:IDX_W];
               rr_ptr_d = ((32'(win) + 32'd1) >= NUM_PORTS) ? '0 : port_id_t'(32'(win) + 32'd1);
               state_d  = SEND_TAG;
            end else if (data_req) begin
               lock_d = 1'b1;
               win_d  = win;
            end
         end
         SEND_TAG: begin
            tag_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
      fifo_pop = req_port_i.data_rvalid && !fifo_empty;
      if (req_port_i.data_rvalid && fifo_empty) err_d = 1'b1;
      // Outputs are quiet while reset is held
      if (rst_i) begin
         data_req  = 1'b0;
         grant     = 1'b0;
         tag_valid = 1'b0;
         fifo_pop  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin : state_reg
      if (rst_i) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         lock_q   <= 1'b0;
         tag_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         lock_q   <= lock_d;
         tag_q    <= tag_d;
         err_q    <= err_d;
      end
   end

   mem_dcache_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (grant),
      .data_i  (id_entry_t'(win)),
      .pop_i   (fifo_pop),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   for (genvar p = 0; p < int'(NUM_PORTS); p++) begin : g_port
      assign s_mem_gnt[p]   = grant && (win == port_id_t'(p));
      assign s_mem_valid[p] = fifo_pop && (fifo_head.id == port_id_t'(p));
      assign s_mem_rdata[p] = req_port_i.data_rdata;
   end

   always_comb begin : req_out
      req_port_o               = '0;
      req_port_o.data_req      = data_req;
      req_port_o.address_index = DC_INDEX_W'(addr_ext[win][IDX_W-1:0]);
      req_port_o.address_tag   = DC_TAG_W'(tag_q);
      req_port_o.tag_valid     = tag_valid;
      req_port_o.data_wdata    = wdata_ext[win];
      req_port_o.data_we       = we_ext[win];
      req_port_o.data_be       = be_ext[win];
      req_port_o.kill_req      = 1'b0;
   end

   assign err_o = err_q;

endmodule
